pkt_rr_arbiter: RTL

- Packet-granular round-robin arbiter that shares one downstream packet FIFO (Avalon-ST, sop/eop/empty) between NUM_PORTS upstream packet streams.
- Once a port is granted, it is locked until its eop beat is accepted, so packets are never interleaved.
- New packets start only while the downstream FIFO's almost_full is low; a packet already in progress always completes.
- Output is one registered stage that drives the FIFO's in_* side directly.

---
 rtl/pkt_rr_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter. It merges NUM_PORTS Avalon-ST packet
// streams into one registered output stage that feeds a packet FIFO. A granted
// port keeps the grant until its eop beat is accepted, so packets never
// interleave. New grants are withheld while the FIFO reports almost_full.
module pkt_rr_arbiter #(
    parameter int unsigned NUM_PORTS        = 4,
    parameter int unsigned SYMBOLS_PER_BEAT = 64,
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    localparam int unsigned DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
    localparam int unsigned EW = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1,
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS*DW-1:0] in_data,
    input  logic [NUM_PORTS-1:0]    in_valid,
    output logic [NUM_PORTS-1:0]    in_ready,
    input  logic [NUM_PORTS-1:0]    in_startofpacket,
    input  logic [NUM_PORTS-1:0]    in_endofpacket,
    input  logic [NUM_PORTS*EW-1:0] in_empty,
    output logic [DW-1:0]           out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_startofpacket,
    output logic                    out_endofpacket,
    output logic [EW-1:0]           out_empty,
    output logic [PW-1:0]           out_port,
    input  logic                    almost_full,
    output logic [31:0]             pkt_count,
    output logic                    proto_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    // High until the first beat of the granted packet has been accepted.
    logic            first_q, first_d;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic [EW-1:0]   out_empty_q, out_empty_d;
    logic [PW-1:0]   out_port_q, out_port_d;
    logic [31:0]     pkt_count_q, pkt_count_d;
    logic            proto_err_q, proto_err_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;

    logic            sel_valid;
    logic [DW-1:0]   sel_data;
    logic            sel_sop;
    logic            sel_eop;
    logic [EW-1:0]   sel_empty;

    logic            out_free;
    logic            accept;
    logic [PW-1:0]   grant_next_ptr;

    // Round-robin search: first requesting port at or after rr_ptr_q.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = PW'((32'(rr_ptr_q) + k) % NUM_PORTS);
            if (!pick_found && in_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the granted port's beat fields.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_empty = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PW'(i)) begin
                sel_valid = in_valid[i];
                sel_data  = in_data[i*DW +: DW];
                sel_sop   = in_startofpacket[i];
                sel_eop   = in_endofpacket[i];
                sel_empty = in_empty[i*EW +: EW];
            end
        end
    end

    // Backpressure: only the granted port sees ready, and only while BUSY.
    always_comb begin
        out_free = !out_valid_q || out_ready;
        accept   = (state_q == ST_BUSY) && sel_valid && out_free;
        in_ready = '0;
        if (state_q == ST_BUSY) begin
            in_ready[grant_q] = out_free;
        end
    end

    // Pointer value that gives the port after the current grant top priority.
    always_comb begin
        if (grant_q == PW'(NUM_PORTS - 1)) begin
            grant_next_ptr = '0;
        end else begin
            grant_next_ptr = grant_q + PW'(1);
        end
    end

    // Arbitration FSM: grant in IDLE, hold the lock in BUSY until eop.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        case (state_q)
            ST_IDLE: begin
                if (!almost_full && pick_found) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (sel_eop) begin
                        rr_ptr_d = grant_next_ptr;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: load on accept, drop valid once consumed, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        out_port_d  = out_port_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sop_d   = sel_sop;
            out_eop_d   = sel_eop;
            out_empty_d = sel_empty;
            out_port_d  = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Packet counter and sticky framing-error flag.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (out_valid_q && out_ready && out_eop_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        proto_err_d = proto_err_q;
        if (accept && (first_q ? !sel_sop : sel_sop)) begin
            proto_err_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_port_q  <= '0;
            pkt_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_port_q  <= out_port_d;
            pkt_count_q <= pkt_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_empty         = out_empty_q;
    assign out_port          = out_port_q;
    assign pkt_count         = pkt_count_q;
    assign proto_err         = proto_err_q;

endmodule
